// File: rtl/dlx_alu_pkg.sv
// dlx_alu_pkg: shared definitions for the DLX ALU issue path.
//   - ALU function codes (also consumed by the ALU itself)
//   - I-type opcodes handled by the issue stage
//   - immediate extension kinds and helper
//   - issue bundle struct carried from decode to the execute stage
package dlx_alu_pkg;

   // ALU function codes
   localparam logic [5:0] FUNC_SLL  = 6'h04;
   localparam logic [5:0] FUNC_SRL  = 6'h06;
   localparam logic [5:0] FUNC_SRA  = 6'h07;
   localparam logic [5:0] FUNC_ADD  = 6'h20;
   localparam logic [5:0] FUNC_ADDU = 6'h21;
   localparam logic [5:0] FUNC_SUB  = 6'h22;
   localparam logic [5:0] FUNC_AND  = 6'h24;
   localparam logic [5:0] FUNC_OR   = 6'h25;
   localparam logic [5:0] FUNC_XOR  = 6'h26;
   localparam logic [5:0] FUNC_SEQ  = 6'h28;
   localparam logic [5:0] FUNC_SNE  = 6'h29;
   localparam logic [5:0] FUNC_SLT  = 6'h2A;
   localparam logic [5:0] FUNC_SGT  = 6'h2B;
   localparam logic [5:0] FUNC_SLE  = 6'h2C;
   localparam logic [5:0] FUNC_SGE  = 6'h2D;
   localparam logic [5:0] FUNC_LHI  = 6'h2E;

   // Opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SUBI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LHI   = 6'h0F;
   localparam logic [5:0] OP_SLLI  = 6'h14;
   localparam logic [5:0] OP_SRLI  = 6'h16;
   localparam logic [5:0] OP_SRAI  = 6'h17;
   localparam logic [5:0] OP_SEQI  = 6'h18;
   localparam logic [5:0] OP_SNEI  = 6'h19;
   localparam logic [5:0] OP_SLTI  = 6'h1A;
   localparam logic [5:0] OP_SGTI  = 6'h1B;
   localparam logic [5:0] OP_SLEI  = 6'h1C;
   localparam logic [5:0] OP_SGEI  = 6'h1D;

   typedef enum logic [1:0] {
      EXT_SIGN,
      EXT_ZERO,
      EXT_SHAMT
   } ext_kind_e;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  func;
      logic [4:0]  rd;
      logic        illegal;
   } issue_bundle_t;

   localparam issue_bundle_t BUNDLE_RESET =
      '{a: 32'h0, b: 32'h0, func: FUNC_ADD, rd: 5'h0, illegal: 1'b0};
   localparam issue_bundle_t BUNDLE_ILLEGAL =
      '{a: 32'h0, b: 32'h0, func: FUNC_ADD, rd: 5'h0, illegal: 1'b1};

   function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_kind_e kind);
      logic [31:0] res;
      res = {{16{imm[15]}}, imm};
      unique case (kind)
         EXT_SIGN:  res = {{16{imm[15]}}, imm};
         EXT_ZERO:  res = {16'h0, imm};
         EXT_SHAMT: res = {27'h0, imm[4:0]};
         default:   res = {{16{imm[15]}}, imm};
      endcase
      return res;
   endfunction

   function automatic logic rtype_func_legal(input logic [5:0] func);
      logic ok;
      unique case (func)
         FUNC_SLL, FUNC_SRL, FUNC_SRA,
         FUNC_ADD, FUNC_ADDU, FUNC_SUB,
         FUNC_AND, FUNC_OR, FUNC_XOR,
         FUNC_SEQ, FUNC_SNE, FUNC_SLT, FUNC_SGT, FUNC_SLE, FUNC_SGE: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dlx_alu_decode.sv
// dlx_alu_decode: combinational DLX instruction -> ALU issue bundle.
//   instr_i     DLX instruction word
//   rs1_val_i   value of register instr[25:21]
//   rs2_val_i   value of register instr[20:16]
//   bundle_o    operands, ALU function code, destination, illegal flag
module dlx_alu_decode
   import dlx_alu_pkg::*;
(
   input  logic [31:0]   instr_i,
   input  logic [31:0]   rs1_val_i,
   input  logic [31:0]   rs2_val_i,
   output issue_bundle_t bundle_o
);

   logic [5:0]  opcode;
   logic [5:0]  rfunc;
   logic [15:0] imm;

   assign opcode = instr_i[31:26];
   assign rfunc  = instr_i[5:0];
   assign imm    = instr_i[15:0];

   logic        legal;
   logic        is_rtype;
   logic        zero_a;
   ext_kind_e   ext_kind;
   logic [5:0]  func;

   always_comb begin
      legal    = 1'b1;
      is_rtype = 1'b0;
      zero_a   = 1'b0;
      ext_kind = EXT_SIGN;
      func     = FUNC_ADD;
      unique case (opcode)
         OP_RTYPE: begin
            is_rtype = 1'b1;
            func     = rfunc;
            legal    = rtype_func_legal(rfunc);
         end
         OP_ADDI: func = FUNC_ADDU;
         OP_SUBI: func = FUNC_SUB;
         OP_ANDI: begin
            func     = FUNC_AND;
            ext_kind = EXT_ZERO;
         end
         OP_ORI: begin
            func     = FUNC_OR;
            ext_kind = EXT_ZERO;
         end
         OP_XORI: begin
            func     = FUNC_XOR;
            ext_kind = EXT_ZERO;
         end
         OP_LHI: begin
            func     = FUNC_LHI;
            ext_kind = EXT_ZERO;
            zero_a   = 1'b1;
         end
         OP_SLLI: begin
            func     = FUNC_SLL;
            ext_kind = EXT_SHAMT;
         end
         OP_SRLI: begin
            func     = FUNC_SRL;
            ext_kind = EXT_SHAMT;
         end
         OP_SRAI: begin
            func     = FUNC_SRA;
            ext_kind = EXT_SHAMT;
         end
         // Set-compare immediates map 0x18..0x1D onto 0x28..0x2D.
         OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI: func = opcode + 6'h10;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      bundle_o = BUNDLE_ILLEGAL;
      if (legal) begin
         bundle_o.a       = zero_a ? 32'h0 : rs1_val_i;
         bundle_o.b       = is_rtype ? rs2_val_i : extend_imm(imm, ext_kind);
         bundle_o.func    = func;
         bundle_o.rd      = is_rtype ? instr_i[15:11] : instr_i[20:16];
         bundle_o.illegal = 1'b0;
      end
   end

endmodule

// File: rtl/dlx_alu_issue.sv
// dlx_alu_issue: DLX decode/issue stage feeding the 32-bit ALU.
//   clk_i, rst_ni          clock, async active-low reset
//   flush_i                synchronous kill of both buffered entries
//   in_valid_i/in_ready_o  instruction handshake (in_ready_o is a flop)
//   instr_i, rs1_val_i, rs2_val_i   instruction and register operands
//   out_valid_o/out_ready_i         issue bundle handshake
//   alu_a_o, alu_b_o, alu_func_o, rd_o, illegal_o   issue bundle
//   issue_cnt_o            wrapping count of bundles taken downstream
// An output register plus one skid register keep in_ready_o off the
// combinational out_ready_i path.
module dlx_alu_issue
   import dlx_alu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] rs1_val_i,
   input  logic [31:0] rs2_val_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic [5:0]  alu_func_o,
   output logic [4:0]  rd_o,
   output logic        illegal_o,
   output logic [15:0] issue_cnt_o
);

   issue_bundle_t dec_bundle;

   dlx_alu_decode u_decode (
      .instr_i   (instr_i),
      .rs1_val_i (rs1_val_i),
      .rs2_val_i (rs2_val_i),
      .bundle_o  (dec_bundle)
   );

   issue_bundle_t out_d, out_q;
   issue_bundle_t skid_d, skid_q;
   logic          out_valid_d, out_valid_q;
   logic          skid_valid_d, skid_valid_q;
   logic [15:0]   cnt_d, cnt_q;

   logic accept;
   logic drain;

   assign accept = in_valid_i & ~skid_valid_q;
   assign drain  = out_valid_q & out_ready_i;

   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         cnt_d = cnt_q + {15'h0, drain};
         if (drain || !out_valid_q) begin
            // Output slot frees up: the older skid entry goes first. While the
            // skid is full in_ready is low, so no input competes with it.
            if (skid_valid_q) begin
               out_d        = skid_q;
               out_valid_d  = 1'b1;
               skid_valid_d = 1'b0;
            end else if (accept) begin
               out_d       = dec_bundle;
               out_valid_d = 1'b1;
            end else begin
               out_valid_d = 1'b0;
            end
         end else if (accept) begin
            skid_d       = dec_bundle;
            skid_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q        <= BUNDLE_RESET;
         skid_q       <= BUNDLE_RESET;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         cnt_q        <= 16'h0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready_o  = ~skid_valid_q;
   assign out_valid_o = out_valid_q;
   assign alu_a_o     = out_q.a;
   assign alu_b_o     = out_q.b;
   assign alu_func_o  = out_q.func;
   assign rd_o        = out_q.rd;
   assign illegal_o   = out_q.illegal;
   assign issue_cnt_o = cnt_q;

endmodule

// File: tb/tb_dlx_alu_issue.sv
module tb_dlx_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [5:0]  alu_func;
   logic [4:0]  rd;
   logic        illegal;
   logic [15:0] issue_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dlx_alu_issue dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .instr_i     (instr),
      .rs1_val_i   (rs1_val),
      .rs2_val_i   (rs2_val),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .alu_a_o     (alu_a),
      .alu_b_o     (alu_b),
      .alu_func_o  (alu_func),
      .rd_o        (rd),
      .illegal_o   (illegal),
      .issue_cnt_o (issue_cnt)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] a;
      logic [31:0] b;
      logic [5:0]  func;
      logic [4:0]  rd;
      logic        ill;
   } vec_t;

   task automatic do_reset();
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      instr     = 32'h0;
      rs1_val   = 32'h0;
      rs2_val   = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      instr = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0;
      @(negedge clk);
      checks += 8;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %h want 1", in_ready); end
      if (alu_a !== 32'h0) begin failures++; $display("FAIL reset_alu_a got %h want 0", alu_a); end
      if (alu_b !== 32'h0) begin failures++; $display("FAIL reset_alu_b got %h want 0", alu_b); end
      if (alu_func !== 6'h20) begin failures++; $display("FAIL reset_alu_func got %h want 20", alu_func); end
      if (rd !== 5'h0) begin failures++; $display("FAIL reset_rd got %h want 0", rd); end
      if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got %h want 0", illegal); end
      if (issue_cnt !== 16'h0) begin failures++; $display("FAIL reset_issue_cnt got %h want 0", issue_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got %h want 0", out_valid); end
   endtask

   task automatic test_decode();
      vec_t v[11];
      v[0]  = '{32'h00221820, 32'd5,        32'd7,   32'd5,        32'd7,        6'h20, 5'd3, 1'b0};
      v[1]  = '{32'h2025FFFC, 32'h10,       32'h0,   32'h10,       32'hFFFFFFFC, 6'h21, 5'd5, 1'b0};
      v[2]  = '{32'h30258001, 32'h10,       32'h0,   32'h10,       32'h00008001, 6'h24, 5'd5, 1'b0};
      v[3]  = '{32'hFC000000, 32'h123,      32'h456, 32'h0,        32'h0,        6'h20, 5'd0, 1'b1};
      v[4]  = '{32'h0022182E, 32'd1,        32'd2,   32'h0,        32'h0,        6'h20, 5'd0, 1'b1};
      v[5]  = '{32'h3C051234, 32'hABCD,     32'h0,   32'h0,        32'h00001234, 6'h2E, 5'd5, 1'b0};
      v[6]  = '{32'h5C22FFE3, 32'h80000000, 32'h0,   32'h80000000, 32'h00000003, 6'h07, 5'd2, 1'b0};
      v[7]  = '{32'h68048000, 32'd9,        32'h0,   32'd9,        32'hFFFF8000, 6'h2A, 5'd4, 1'b0};
      v[8]  = '{32'h00221807, 32'd5,        32'd6,   32'd5,        32'd6,        6'h07, 5'd3, 1'b0};
      v[9]  = '{32'h3406F00F, 32'd3,        32'h0,   32'd3,        32'h0000F00F, 6'h25, 5'd6, 1'b0};
      v[10] = '{32'h00221823, 32'd1,        32'd2,   32'h0,        32'h0,        6'h20, 5'd0, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         instr    = v[i].instr;
         rs1_val  = v[i].rs1;
         rs2_val  = v[i].rs2;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         checks += 6;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL dec%0d_out_valid got %h want 1", i, out_valid); end
         if (alu_a !== v[i].a) begin failures++; $display("FAIL dec%0d_alu_a got %h want %h", i, alu_a, v[i].a); end
         if (alu_b !== v[i].b) begin failures++; $display("FAIL dec%0d_alu_b got %h want %h", i, alu_b, v[i].b); end
         if (alu_func !== v[i].func) begin failures++; $display("FAIL dec%0d_alu_func got %h want %h", i, alu_func, v[i].func); end
         if (rd !== v[i].rd) begin failures++; $display("FAIL dec%0d_rd got %h want %h", i, rd, v[i].rd); end
         if (illegal !== v[i].ill) begin failures++; $display("FAIL dec%0d_illegal got %h want %h", i, illegal, v[i].ill); end
      end
      @(negedge clk);
      @(negedge clk);
      checks += 2;
      if (issue_cnt !== 16'd11) begin failures++; $display("FAIL dec_issue_cnt got %0d want 11", issue_cnt); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL dec_drained got %h want 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [31:0] bp_rs1[4];
      int sent = 0;
      int got  = 0;
      logic fire_in, fire_out;
      bp_rs1[0] = 32'd11; bp_rs1[1] = 32'd22; bp_rs1[2] = 32'd33; bp_rs1[3] = 32'd44;
      do_reset();
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 4);
         if (sent < 4) begin
            in_valid = 1'b1;
            instr    = (32'(sent + 1) << 11) | 32'h20;
            rs1_val  = bp_rs1[sent];
            rs2_val  = 32'(100 + sent);
         end else begin
            in_valid = 1'b0;
         end
         if (cyc == 2 || cyc == 3) begin
            checks += 3;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_in_ready c%0d got %h want 0", cyc, in_ready); end
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_stall_out_valid c%0d got %h want 1", cyc, out_valid); end
            if (alu_a !== 32'd11) begin failures++; $display("FAIL bp_stall_alu_a c%0d got %0d want 11", cyc, alu_a); end
         end
         if (cyc == 4) begin
            checks += 2;
            if (sent !== 2) begin failures++; $display("FAIL bp_accepted got %0d want 2", sent); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_drain got %h want 0", in_ready); end
         end
         if (cyc == 5) begin
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_rise got %h want 1", in_ready); end
         end
         fire_in  = in_valid & in_ready;
         fire_out = out_valid & out_ready;
         if (fire_out) begin
            checks += 3;
            if (alu_a !== bp_rs1[got]) begin failures++; $display("FAIL bp_order_a%0d got %0d want %0d", got, alu_a, bp_rs1[got]); end
            if (rd !== 5'(got + 1)) begin failures++; $display("FAIL bp_order_rd%0d got %0d want %0d", got, rd, got + 1); end
            if (alu_b !== 32'(100 + got)) begin failures++; $display("FAIL bp_order_b%0d got %0d want %0d", got, alu_b, 100 + got); end
            got++;
         end
         @(posedge clk);
         if (fire_in) sent++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 4) begin failures++; $display("FAIL bp_received got %0d want 4", got); end
      @(negedge clk);
      checks += 2;
      if (issue_cnt !== 16'd4) begin failures++; $display("FAIL bp_issue_cnt got %0d want 4", issue_cnt); end
      if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_final_out_valid got %h want 0", out_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; instr = 32'h00000820; rs1_val = 32'h51; rs2_val = 32'h0;
      @(negedge clk);
      instr = 32'h00001020; rs1_val = 32'h52;
      @(negedge clk);
      checks += 2;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_full_in_ready got %h want 0", in_ready); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_full_out_valid got %h want 1", out_valid); end
      flush = 1'b1; out_ready = 1'b1;
      instr = 32'h00001820; rs1_val = 32'h99;
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got %h want 0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got %h want 1", in_ready); end
      if (issue_cnt !== 16'd0) begin failures++; $display("FAIL flush_issue_cnt got %0d want 0", issue_cnt); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost%0d out_valid got %h want 0", i, out_valid); end
      end
      checks++;
      if (issue_cnt !== 16'd0) begin failures++; $display("FAIL flush_cnt_after got %0d want 0", issue_cnt); end
   endtask

   task automatic test_async_reset();
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; instr = 32'h00221820; rs1_val = 32'd5; rs2_val = 32'd7;
      @(negedge clk);
      out_ready = 1'b1; rs1_val = 32'd6;
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0;
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_out_valid got %h want 1", out_valid); end
      if (issue_cnt !== 16'd1) begin failures++; $display("FAIL ar_pre_issue_cnt got %0d want 1", issue_cnt); end
      if (alu_a !== 32'd6) begin failures++; $display("FAIL ar_pre_alu_a got %0d want 6", alu_a); end
      #2;
      rst_n = 1'b0;
      #1;
      checks += 8;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got %h want 0", out_valid); end
      if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got %h want 1", in_ready); end
      if (alu_a !== 32'h0) begin failures++; $display("FAIL ar_alu_a got %h want 0", alu_a); end
      if (alu_b !== 32'h0) begin failures++; $display("FAIL ar_alu_b got %h want 0", alu_b); end
      if (alu_func !== 6'h20) begin failures++; $display("FAIL ar_alu_func got %h want 20", alu_func); end
      if (rd !== 5'h0) begin failures++; $display("FAIL ar_rd got %h want 0", rd); end
      if (illegal !== 1'b0) begin failures++; $display("FAIL ar_illegal got %h want 0", illegal); end
      if (issue_cnt !== 16'h0) begin failures++; $display("FAIL ar_issue_cnt got %h want 0", issue_cnt); end
   endtask

   task automatic test_wrap();
      int budget = 0;
      do_reset();
      in_valid = 1'b1; out_ready = 1'b1;
      instr = 32'h00221820; rs1_val = 32'd1; rs2_val = 32'd2;
      @(negedge clk);
      while (issue_cnt !== 16'hFFFF && budget < 70000) begin
         @(negedge clk);
         budget++;
      end
      in_valid = 1'b0;
      checks += 2;
      if (issue_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_reach got %h want ffff", issue_cnt); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL wrap_out_valid got %h want 1", out_valid); end
      @(posedge clk);
      #1;
      checks++;
      if (issue_cnt !== 16'h0) begin failures++; $display("FAIL wrap_issue_cnt got %h want 0", issue_cnt); end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
